// File: rtl/fill_engine.sv
// fill_engine
//   Rectangle draw engine driving port B of the 320x200 1-bit framebuffer ram.
//   Accepts one command (rectangle + op). It then walks the rectangle in
//   row-major order, with x changing fastest, and issues one ram request per
//   pixel using the request/rdy_b handshake.
//
//   Ports
//     clk, rst                 clock and asynchronous active-low reset
//     cmd_valid/cmd_ready      command handshake; ready only while idle/done
//     cmd_op                   0 CLEAR, 1 SET, 2 INVERT (read-modify-write), 3 no-op
//     cmd_x0/y0/x1/y1          inclusive rectangle corners; x1/y1 are clamped
//     x_b, y_b                 ram address, held while idle
//     read_b, write_b, in_b    ram request strobes and write data
//     out_b, rdy_b             ram read data and accept/complete strobe
//     busy, done               command in progress / one-cycle completion pulse
//     px_count                 pixels written by the last or current command
module fill_engine #(
  parameter int H_RES = 320,
  parameter int V_RES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [8:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  output logic [8:0]  x_b,
  output logic [7:0]  y_b,
  output logic        read_b,
  output logic        write_b,
  output logic        in_b,
  input  logic        out_b,
  input  logic        rdy_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] px_count
);

  localparam logic [8:0] X_MAX = 9'(H_RES - 1);
  localparam logic [7:0] Y_MAX = 8'(V_RES - 1);

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_SET    = 2'd1;
  localparam logic [1:0] OP_INVERT = 2'd2;
  localparam logic [1:0] OP_NOP    = 2'd3;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Operands that must survive the whole walk. y0 is not needed after
  // accept because rows only ever advance.
  typedef struct packed {
    logic [1:0] op;
    logic [8:0] x0;
    logic [8:0] x1;
    logic [7:0] y1;
  } cmd_t;

  state_t     state;
  cmd_t       cur;
  logic [8:0] x1_clamp;
  logic [7:0] y1_clamp;
  logic       empty;
  logic       last_px;

  always_comb begin
    x1_clamp = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
    y1_clamp = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
  end

  // A no-op command takes the same path as an empty rectangle.
  assign empty   = (cmd_op == OP_NOP) || (cmd_x0 > x1_clamp) || (cmd_y0 > y1_clamp);
  assign last_px = (x_b == cur.x1) && (y_b == cur.y1);

  // All outputs are registered. busy tracks "a request is on the pins".
  // cmd_ready is high exactly in IDLE and DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= '0;
      x_b       <= '0;
      y_b       <= '0;
      read_b    <= 1'b0;
      write_b   <= 1'b0;
      in_b      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      px_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new command exactly as IDLE does. This allows
        // back-to-back commands without a bubble.
        IDLE, DONE: begin
          state <= IDLE;
          if (cmd_valid) begin
            cur.op   <= cmd_op;
            cur.x0   <= cmd_x0;
            cur.x1   <= x1_clamp;
            cur.y1   <= y1_clamp;
            px_count <= '0;
            if (empty) begin
              // The ram is never touched. The address keeps its last value.
              state     <= DONE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              x_b       <= cmd_x0;
              y_b       <= cmd_y0;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              if (cmd_op == OP_INVERT) begin
                state  <= RD;
                read_b <= 1'b1;
              end else begin
                state   <= WR;
                write_b <= 1'b1;
                in_b    <= (cmd_op == OP_SET);
              end
            end
          end
        end

        RD: begin
          if (rdy_b) begin
            // Read data is valid only in the rdy_b cycle. The inverted
            // value becomes the write data for the same pixel.
            read_b  <= 1'b0;
            write_b <= 1'b1;
            in_b    <= ~out_b;
            state   <= WR;
          end
        end

        WR: begin
          if (rdy_b) begin
            px_count <= px_count + 16'd1;
            if (last_px) begin
              write_b   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= DONE;
            end else begin
              if (x_b < cur.x1) begin
                x_b <= x_b + 9'd1;
              end else begin
                x_b <= cur.x0;
                y_b <= y_b + 8'd1;
              end
              // CLEAR/SET keep write_b high and stream 1 px/clk. INVERT
              // alternates between read and write.
              if (cur.op == OP_INVERT) begin
                write_b <= 1'b0;
                read_b  <= 1'b1;
                state   <= RD;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_engine.sv
module tb_fill_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x0, cmd_x1;
  logic [7:0]  cmd_y0, cmd_y1;
  logic [8:0]  x_b;
  logic [7:0]  y_b;
  logic        read_b, write_b, in_b, out_b, rdy_b, busy, done;
  logic [15:0] px_count;

  always #5 clk = ~clk;

  fill_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1),
    .cmd_y1(cmd_y1), .x_b(x_b), .y_b(y_b), .read_b(read_b), .write_b(write_b),
    .in_b(in_b), .out_b(out_b), .rdy_b(rdy_b), .busy(busy), .done(done),
    .px_count(px_count)
  );

  typedef struct {int x; int y; int v;} px_t;
  typedef struct {int op; int x0; int y0; int x1; int y1; int mode; int exp_done; int exp_px;} vec_t;

  bit  ram [200][320];
  px_t expq[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // mode 0: rdy_b tied high; mode 1: each request stalls 3 cycles;
  // mode 2: random rdy_b and garbage commands while busy.
  // exp_done: cycle (1 = first cycle after accept) of the done pulse, 0 = don't check.
  // exp_px: required px_count, -1 = take it from the model.
  // abort_at: nonzero = pull reset after that many writes.
  task automatic run_cmd(input int op, input int x0i, input int y0i, input int x1i, input int y1i,
                         input int mode, input int exp_done, input int exp_px, input int abort_at);
    int x0, y0, x1, y1, cx1, cy1, k, nwr, sc, last_x, last_y, budget, npx;
    bit got_done;
    logic p_req, p_rdy, p_rd, p_wr, p_in;
    logic [8:0] p_x;
    logic [7:0] p_y;
    px_t e;
    x0 = x0i & 'h1ff; x1 = x1i & 'h1ff; y0 = y0i & 'hff; y1 = y1i & 'hff;
    cx1 = (x1 > 319) ? 319 : x1;
    cy1 = (y1 > 199) ? 199 : y1;
    expq.delete();
    if (op != 3 && x0 <= cx1 && y0 <= cy1)
      for (int y = y0; y <= cy1; y++)
        for (int x = x0; x <= cx1; x++)
          expq.push_back('{x, y, (op == 2) ? int'(!ram[y][x]) : (op & 1)});
    npx = expq.size();
    if (exp_px < 0) exp_px = npx;
    last_x = (npx > 0) ? expq[npx-1].x : int'(x_b);
    last_y = (npx > 0) ? expq[npx-1].y : int'(y_b);
    budget = (mode == 0) ? 2*npx + 20 : (mode == 1) ? 9*npx + 20 : 20*npx + 40;

    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'(op);
    cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_x1 = 9'(x1); cmd_y1 = 8'(y1);
    rdy_b = 1'b0;
    k = 0; nwr = 0; sc = 0; got_done = 0; p_req = 0; p_rdy = 0;
    p_rd = 0; p_wr = 0; p_in = 0; p_x = '0; p_y = '0;

    while (!got_done && k < budget) begin
      @(negedge clk);
      k++;
      if (abort_at != 0 && nwr == abort_at) begin
        rst = 1'b0; cmd_valid = 1'b0; rdy_b = 1'b0;
        #1;
        chk("abort_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_req", {read_b, write_b}, 0);
        chk("abort_xy", {x_b, y_b}, 0);
        chk("abort_in", in_b, 0);
        chk("abort_px", px_count, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_no_write", write_b, 0);
        end
        return;
      end
      cmd_valid = (mode == 2 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cmd_valid) begin
        cmd_op = 2'($urandom); cmd_x0 = 9'($urandom); cmd_y0 = 8'($urandom);
        cmd_x1 = 9'($urandom); cmd_y1 = 8'($urandom);
      end
      chk("rw_exclusive", read_b & write_b, 0);
      chk("busy_is_req", busy, read_b | write_b);
      chk("ready_not_busy", cmd_ready, !busy);
      chk("px_running", px_count, nwr);
      if (p_req && !p_rdy) begin
        chk("stall_xy", {x_b, y_b}, {p_x, p_y});
        chk("stall_req", {read_b, write_b}, {p_rd, p_wr});
        if (write_b) chk("stall_in", in_b, p_in);
      end
      if (done) begin
        got_done = 1;
        if (exp_done > 0) chk("done_cycle", k, exp_done);
        chk("done_px", px_count, exp_px);
        chk("done_model_px", nwr, npx);
        chk("done_q_empty", expq.size(), 0);
        chk("done_xy_hold", {x_b, y_b}, {9'(last_x), 8'(last_y)});
      end else begin
        if (read_b | write_b) begin
          case (mode)
            0: rdy_b = 1'b1;
            1: begin rdy_b = (sc == 3); sc = rdy_b ? 0 : sc + 1; end
            default: rdy_b = ($urandom_range(0, 3) != 0);
          endcase
        end else rdy_b = 1'b0;
        out_b = read_b ? ram[y_b][x_b] : 1'($urandom_range(0, 1));
        if (read_b) begin
          chk("read_op", op, 2);
          if (expq.size() > 0) chk("read_xy", {x_b, y_b}, {9'(expq[0].x), 8'(expq[0].y)});
        end
        if (write_b && rdy_b) begin
          if (expq.size() == 0) chk("extra_write", 1, 0);
          else begin
            e = expq.pop_front();
            chk("write_xy", {x_b, y_b}, {9'(e.x), 8'(e.y)});
            chk("write_data", in_b, e.v);
            ram[y_b][x_b] = in_b;
            nwr++;
          end
        end
      end
      p_req = read_b | write_b; p_rdy = rdy_b; p_rd = read_b; p_wr = write_b;
      p_in = in_b; p_x = x_b; p_y = y_b;
    end
    cmd_valid = 1'b0; rdy_b = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_req", {read_b, write_b}, 0);
    chk("idle_px_hold", px_count, exp_px);
  endtask

  vec_t tbl[10];

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; rdy_b = 1'b0; out_b = 1'b0;
    cmd_op = '0; cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {busy, done, read_b, write_b, in_b}, 0);
    chk("rst_xy", {x_b, y_b}, 0);
    chk("rst_px", px_count, 0);
    rst = 1'b1;

    tbl[0] = '{1,   0,   0,   1,   1, 0,  5,  4};
    tbl[1] = '{0, 310, 198, 400, 250, 0, 21, 20};
    tbl[2] = '{1,   5,   0,   4,   0, 0,  1,  0};
    tbl[3] = '{2,   7,   3,   7,   3, 0,  3,  1};
    tbl[4] = '{1,   0,   0,   2,   0, 1, 13,  3};
    tbl[5] = '{3,   0,   0,   5,   5, 0,  1,  0};
    tbl[6] = '{2, 100,  50, 103,  51, 0, 17,  8};
    tbl[7] = '{0, 330,   0, 340,   0, 0,  1,  0};
    tbl[8] = '{1,   0,   9,   3,   8, 0,  1,  0};
    tbl[9] = '{2,  20,  20,  21,  20, 1, 17,  2};
    ram[3][7] = 1'b1;
    ram[20][21] = 1'b1;
    foreach (tbl[i])
      run_cmd(tbl[i].op, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1,
              tbl[i].mode, tbl[i].exp_done, tbl[i].exp_px, 0);

    for (int i = 0; i < 40; i++) begin
      int x0, y0, x1, y1;
      x0 = $urandom_range(0, 330);
      y0 = $urandom_range(0, 205);
      x1 = ($urandom_range(0, 5) == 0) ? x0 - 1 : x0 + $urandom_range(0, 10);
      y1 = y0 + $urandom_range(0, 4);
      run_cmd($urandom_range(0, 3), x0, y0, x1, y1, 2, 0, -1, 0);
    end

    run_cmd(0, 0, 0, 319, 199, 0, 0, -1, 1000);
    run_cmd(0, 0, 0, 319, 199, 0, 64001, 64000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
